// File: rtl/ps2_mouse_tracker.sv
// ============================================================================
// ps2_mouse_tracker : enables PS/2 mouse streaming and tracks a cursor
// Rev 1.0
// ============================================================================
`default_nettype none

module ps2_mouse_tracker #(
  parameter int X_RES   = 640,
  parameter int Y_RES   = 480,
  parameter int COORD_W = 10,
  parameter int SHIFT   = 0,
  parameter int WRAP    = 0,
  parameter int TIMEOUT = 100000
) (
  input  logic               clk,
  input  logic               reset,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_done,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic [COORD_W-1:0] pixelx,
  output logic [COORD_W-1:0] pixely,
  output logic [2:0]         buttons,
  output logic               mouseclick,
  output logic               packet_valid,
  output logic               streaming
);

  localparam logic [2:0] S_SEND     = 3'd0;
  localparam logic [2:0] S_WAIT_TX  = 3'd1;
  localparam logic [2:0] S_WAIT_ACK = 3'd2;
  localparam logic [2:0] S_BYTE1    = 3'd3;
  localparam logic [2:0] S_BYTE2    = 3'd4;
  localparam logic [2:0] S_BYTE3    = 3'd5;
  localparam logic [2:0] S_UPDATE   = 3'd6;

  localparam int SW = COORD_W + 2;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] C_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] C_ACK        = 8'hFA;

  logic [2:0]         state_q, state_d;
  logic [TW-1:0]      cnt_q, cnt_d;
  logic               streaming_q, streaming_d;
  // {y_ovf, x_ovf, y_sign, x_sign, middle, right, left}
  logic [6:0]         b1_q, b1_d;
  logic [7:0]         x_lo_q, x_lo_d;
  logic [7:0]         y_lo_q, y_lo_d;
  logic [COORD_W-1:0] pixelx_q, pixelx_d;
  logic [COORD_W-1:0] pixely_q, pixely_d;
  logic [2:0]         buttons_q, buttons_d;

  logic               w_timeout;
  logic               w_waiting;
  logic signed [8:0]  w_dx;
  logic signed [8:0]  w_dy;
  logic signed [SW-1:0] w_sum_x;
  logic signed [SW-1:0] w_sum_y;

  // Wrap folds by a single period; deltas never exceed one screen span.
  function automatic logic [COORD_W-1:0] limit(input logic signed [SW-1:0] v,
                                               input int res);
    logic signed [SW-1:0] r;
    logic signed [SW-1:0] t;
    r = SW'(res);
    if (WRAP != 0) begin
      if (v < 0)       t = v + r;
      else if (v >= r) t = v - r;
      else             t = v;
    end else begin
      if (v < 0)       t = '0;
      else if (v >= r) t = r - SW'(1);
      else             t = v;
    end
    return COORD_W'(t);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_SEND;
      cnt_q       <= '0;
      streaming_q <= 1'b0;
      b1_q        <= '0;
      x_lo_q      <= '0;
      y_lo_q      <= '0;
      pixelx_q    <= COORD_W'(X_RES / 2);
      pixely_q    <= COORD_W'(Y_RES / 2);
      buttons_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      streaming_q <= streaming_d;
      b1_q        <= b1_d;
      x_lo_q      <= x_lo_d;
      y_lo_q      <= y_lo_d;
      pixelx_q    <= pixelx_d;
      pixely_q    <= pixely_d;
      buttons_q   <= buttons_d;
    end
  end

  assign w_timeout = (cnt_q == TW'(TIMEOUT - 1));
  assign w_waiting = (state_q == S_WAIT_ACK) || (state_q == S_BYTE2) ||
                     (state_q == S_BYTE3);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SEND:     state_d = S_WAIT_TX;
      S_WAIT_TX:  if (tx_done) state_d = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (rx_valid)       state_d = (rx_data == C_ACK) ? S_BYTE1 : S_SEND;
        else if (w_timeout) state_d = S_SEND;
      end
      S_BYTE1:    if (rx_valid && rx_data[3]) state_d = S_BYTE2;
      S_BYTE2: begin
        if (rx_valid)       state_d = S_BYTE3;
        else if (w_timeout) state_d = S_BYTE1;
      end
      S_BYTE3: begin
        if (rx_valid)       state_d = S_UPDATE;
        else if (w_timeout) state_d = S_BYTE1;
      end
      S_UPDATE:   state_d = S_BYTE1;
      default:    state_d = S_SEND;
    endcase
  end

  assign w_dx    = $signed({b1_q[3], x_lo_q}) >>> SHIFT;
  assign w_dy    = $signed({b1_q[4], y_lo_q}) >>> SHIFT;
  assign w_sum_x = $signed({2'b00, pixelx_q}) + $signed({{(SW-9){w_dx[8]}}, w_dx});
  assign w_sum_y = $signed({2'b00, pixely_q}) - $signed({{(SW-9){w_dy[8]}}, w_dy});

  always_comb begin
    cnt_d       = cnt_q + TW'(1);
    streaming_d = streaming_q;
    b1_d        = b1_q;
    x_lo_d      = x_lo_q;
    y_lo_d      = y_lo_q;
    pixelx_d    = pixelx_q;
    pixely_d    = pixely_q;
    buttons_d   = buttons_q;

    if (rx_valid || (state_d != state_q) || !w_waiting) cnt_d = '0;

    if (state_q == S_WAIT_ACK && rx_valid && rx_data == C_ACK) streaming_d = 1'b1;
    if (state_q == S_BYTE1 && rx_valid && rx_data[3])
      b1_d = {rx_data[7:4], rx_data[2:0]};
    if (state_q == S_BYTE2 && rx_valid) x_lo_d = rx_data;
    if (state_q == S_BYTE3 && rx_valid) y_lo_d = rx_data;

    if (state_q == S_UPDATE) begin
      if (!b1_q[5]) pixelx_d = limit(w_sum_x, X_RES);
      if (!b1_q[6]) pixely_d = limit(w_sum_y, Y_RES);
      buttons_d = b1_q[2:0];
    end
  end

  // tx_start is masked by reset so nothing is requested while held in SEND.
  always_comb begin
    tx_start     = (state_q == S_SEND) && !reset;
    tx_data      = C_CMD_ENABLE;
    packet_valid = (state_q == S_UPDATE);
    mouseclick   = (state_q == S_UPDATE) && b1_q[0] && !buttons_q[0];
  end

  assign pixelx    = pixelx_q;
  assign pixely    = pixely_q;
  assign buttons   = buttons_q;
  assign streaming = streaming_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_mouse_tracker.sv
// ============================================================================
// tb_ps2_mouse_tracker : clamp and wrap instances checked against a packet model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ps2_mouse_tracker;

  localparam int X_RES   = 640;
  localparam int Y_RES   = 480;
  localparam int SHIFT   = 0;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset, tx_done, rx_valid;
  logic [7:0] rx_data;

  logic       tx_start_o [2];
  logic [7:0] tx_data_o  [2];
  logic [9:0] px         [2];
  logic [9:0] py         [2];
  logic [2:0] btn        [2];
  logic       mc         [2];
  logic       pv         [2];
  logic       st         [2];

  always #5 clk = ~clk;

  ps2_mouse_tracker #(.X_RES(X_RES), .Y_RES(Y_RES), .COORD_W(10), .SHIFT(SHIFT),
                      .WRAP(0), .TIMEOUT(TIMEOUT)) u_clamp (
    .clk(clk), .reset(reset), .tx_start(tx_start_o[0]), .tx_data(tx_data_o[0]),
    .tx_done(tx_done), .rx_valid(rx_valid), .rx_data(rx_data),
    .pixelx(px[0]), .pixely(py[0]), .buttons(btn[0]), .mouseclick(mc[0]),
    .packet_valid(pv[0]), .streaming(st[0]));

  ps2_mouse_tracker #(.X_RES(X_RES), .Y_RES(Y_RES), .COORD_W(10), .SHIFT(SHIFT),
                      .WRAP(1), .TIMEOUT(TIMEOUT)) u_wrap (
    .clk(clk), .reset(reset), .tx_start(tx_start_o[1]), .tx_data(tx_data_o[1]),
    .tx_done(tx_done), .rx_valid(rx_valid), .rx_data(rx_data),
    .pixelx(px[1]), .pixely(py[1]), .buttons(btn[1]), .mouseclick(mc[1]),
    .packet_valid(pv[1]), .streaming(st[1]));

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: cursor per instance (index = WRAP value), shared protocol state.
  int         mx [2];
  int         my [2];
  logic [2:0] mb;
  bit         mstream, exp_tx, exp_pv, exp_mc, pend;
  logic [7:0] q [$];
  logic [7:0] pb1, pb2, pb3;
  int         edges;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int fold(input int v, input int res, input int wrap);
    if (wrap != 0) return ((v % res) + res) % res;
    if (v < 0) return 0;
    if (v > res - 1) return res - 1;
    return v;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      mx[w] = X_RES / 2;
      my[w] = Y_RES / 2;
    end
    mb = 3'b000; mstream = 0; exp_tx = 0; exp_pv = 0; exp_mc = 0; pend = 0;
    q.delete(); edges = 0;
  endtask

  task automatic apply_packet();
    int dx, dy;
    dx = pb1[4] ? int'(pb2) - 256 : int'(pb2);
    dy = pb1[5] ? int'(pb3) - 256 : int'(pb3);
    dx = dx >>> SHIFT;
    dy = dy >>> SHIFT;
    for (int w = 0; w < 2; w++) begin
      if (!pb1[6]) mx[w] = fold(mx[w] + dx, X_RES, w);
      if (!pb1[7]) my[w] = fold(my[w] - dy, Y_RES, w);
    end
    mb = pb1[2:0];
  endtask

  // Called once the DUT has sampled byte b.
  task automatic model_byte(input logic [7:0] b);
    if (!mstream) begin
      if (b == 8'hFA) mstream = 1; else exp_tx = 1;
      edges = 0;
      return;
    end
    if (q.size() > 0 && edges - 1 >= TIMEOUT) q.delete();
    edges = 0;
    if (q.size() == 0 && !b[3]) return;
    q.push_back(b);
    if (q.size() == 3) begin
      pb1 = q[0]; pb2 = q[1]; pb3 = q[2];
      q.delete();
      pend   = 1;
      exp_pv = 1;
      exp_mc = pb1[0] && !mb[0];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    exp_tx = 0; exp_pv = 0; exp_mc = 0;
    edges++;
    if (pend) begin
      apply_packet();
      pend = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic [7:0] b);
    step();
    rx_valid = 1'b1; rx_data = b;
    step();
    rx_valid = 1'b0;
    model_byte(b);
  endtask

  task automatic tx_pulse();
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  task automatic pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send(a); idle(3);
    send(b); idle(3);
    send(c); idle(3);
  endtask

  task automatic release_and_enable();
    reset = 1'b0; exp_tx = 1; edges = 0;
    tx_pulse();
    send(8'hFA);
    idle(3);
  endtask

  task automatic lit(input string name, input int w, input int ex, input int ey);
    check({name, "_x"}, 32'(px[w]), ex);
    check({name, "_y"}, 32'(py[w]), ey);
  endtask

  always @(negedge clk) begin
    for (int w = 0; w < 2; w++) begin
      check($sformatf("pixelx%0d", w), 32'(px[w]), mx[w]);
      check($sformatf("pixely%0d", w), 32'(py[w]), my[w]);
      check($sformatf("buttons%0d", w), 32'(btn[w]), 32'(mb));
      check($sformatf("streaming%0d", w), 32'(st[w]), 32'(mstream));
      check($sformatf("tx_start%0d", w), 32'(tx_start_o[w]), 32'(exp_tx));
      check($sformatf("tx_data%0d", w), 32'(tx_data_o[w]), 32'h0000_00F4);
      check($sformatf("packet_valid%0d", w), 32'(pv[w]), 32'(exp_pv));
      check($sformatf("mouseclick%0d", w), 32'(mc[w]), 32'(exp_mc));
    end
  end

  initial begin
    reset = 1'b1; tx_done = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    model_reset();
    idle(2);
    lit("reset", 0, 320, 240);
    check("reset_streaming", 32'(st[0]), 0);

    // First enable attempt is NAKed with FC, forcing a second F4 request.
    reset = 1'b0; exp_tx = 1; edges = 0;
    tx_pulse();
    send(8'hFC);
    tx_pulse();
    send(8'hFA);
    idle(3);
    check("enable_streaming", 32'(st[1]), 1);
    lit("enable", 0, 320, 240);

    pkt(8'h09, 8'h05, 8'h03);
    lit("pkt1", 0, 325, 237);
    check("pkt1_buttons", 32'(btn[0]), 1);

    send(8'h00); idle(3);
    pkt(8'h08, 8'h02, 8'h00);
    lit("resync", 1, 327, 237);

    send(8'h08); idle(3);
    send(8'h05); idle(TIMEOUT + 1);
    pkt(8'h08, 8'h01, 8'h00);
    lit("timeout", 0, 328, 237);

    pkt(8'h48, 8'h7F, 8'h00);
    lit("x_ovf", 0, 328, 237);

    // Reset in the middle of a packet.
    send(8'h08); idle(2);
    reset = 1'b1;
    model_reset();
    idle(2);
    release_and_enable();
    lit("rereset", 0, 320, 240);

    repeat (3) pkt(8'h18, 8'h00, 8'h00);
    lit("clamp_lo", 0, 0, 240);
    lit("wrap_neg", 1, 192, 240);

    pkt(8'h08, 8'hFF, 8'h00);
    pkt(8'h08, 8'hC0, 8'h00);
    lit("to_edge", 1, 639, 240);
    pkt(8'h08, 8'h01, 8'h00);
    lit("wrap_hi", 1, 0, 240);
    lit("clamp_mid", 0, 448, 240);
    pkt(8'h08, 8'hFF, 8'h00);
    lit("clamp_hi", 0, 639, 240);

    pkt(8'h2E, 8'h00, 8'h00);
    lit("y_clamp", 0, 639, 479);
    lit("y_wrap", 1, 255, 16);
    check("buttons_rm", 32'(btn[1]), 6);

    pkt(8'h89, 8'h01, 8'h7F);
    lit("y_ovf", 1, 256, 16);

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
